// File: rtl/mini_core_rrv_pkg.sv
// Shared definitions for the mini_core_rrv boot and run controller.
//   t_boot_state   : controller FSM encoding (visible on the state port)
//   EOT_PASS_CODE  : end-of-test code that means "test passed"
//   BOOT_ERR_*     : bit positions inside the err output
//   BOOT_BASE_ADDR / BOOT_DEPTH : default load window derived from the i_mem map
package mini_core_rrv_pkg;

    localparam logic [31:0] I_MEM_OFFSET = 32'h0000_0000;
    localparam int          I_MEM_SIZE   = 4096;            // bytes

    localparam logic [31:0] BOOT_BASE_ADDR = I_MEM_OFFSET;
    localparam int          BOOT_DEPTH     = I_MEM_SIZE / 4; // words

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } t_boot_state;

    localparam logic [7:0] EOT_PASS_CODE = 8'h00;

    localparam int BOOT_ERR_OVF = 0;
    localparam int BOOT_ERR_TMO = 1;

endpackage

// File: rtl/mini_core_rrv_boot_wdog.sv
// Run-phase cycle counter and watchdog.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the counter (wins over enable)
//   enable     : count this cycle (core is running)
//   limit      : watchdog limit in cycles, 0 disables the watchdog
//   count      : cycles counted since the last clear, saturating at all-ones
//   timeout    : combinational pulse during the limit-th enabled cycle
module mini_core_rrv_boot_wdog #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             timeout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && (count != '1))
            count <= count + CNT_W'(1);
    end

    // count holds k-1 during the k-th enabled cycle, so matching limit-1
    // fires on exactly the limit-th run cycle.
    assign timeout = enable && (limit != '0) && (count == limit - CNT_W'(1));

endmodule

// File: rtl/mini_core_rrv_boot_ctrl.sv
// Boot and run controller for a mini_core_rrv core.
// Streams a program into i_mem while holding the core in reset, then
// releases the core and supervises the run (end-of-test and watchdog).
//   clk, rst_n                          : clock, asynchronous active-low reset
//   load_start                          : pulse to start a load (IDLE/DONE/ERR)
//   in_valid/in_ready/in_data/in_last   : program word stream
//   imem_we/imem_addr/imem_wdata        : registered i_mem write port
//   core_rst                            : active-high core reset
//   eot_valid/eot_code                  : end-of-test report from the core
//   timeout_limit                       : watchdog limit, 0 = off
//   state/done/pass/err                 : status
//   word_cnt/cycle_cnt                  : words loaded, cycles run
module mini_core_rrv_boot_ctrl
    import mini_core_rrv_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BOOT_BASE_ADDR),
    parameter int                DEPTH     = BOOT_DEPTH,
    parameter int                CNT_W     = 32,
    localparam int               WC_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst,
    input  logic              eot_valid,
    input  logic [7:0]        eot_code,
    input  logic [CNT_W-1:0]  timeout_limit,
    output logic [2:0]        state,
    output logic              done,
    output logic              pass,
    output logic [1:0]        err,
    output logic [WC_W-1:0]   word_cnt,
    output logic [CNT_W-1:0]  cycle_cnt
);

    t_boot_state cur;
    logic        beat;
    logic        full;
    logic        restart;
    logic        wd_clear;
    logic        wd_timeout;

    assign state   = cur;
    assign beat    = in_valid && in_ready;
    assign full    = (word_cnt == WC_W'(DEPTH));
    assign restart = load_start && (cur inside {ST_IDLE, ST_DONE, ST_ERR});

    // Counter is held at zero for the whole load, so it enters RUN cleared.
    assign wd_clear = restart || (cur == ST_LOAD);

    mini_core_rrv_boot_wdog #(
        .CNT_W (CNT_W)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .enable  (cur == ST_RUN),
        .limit   (timeout_limit),
        .count   (cycle_cnt),
        .timeout (wd_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= ST_IDLE;
            core_rst   <= 1'b1;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err        <= '0;
            word_cnt   <= '0;
        end else begin
            imem_we <= 1'b0;
            case (cur)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (load_start) begin
                        cur      <= ST_LOAD;
                        in_ready <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        err      <= '0;
                        word_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    if (!in_ready) begin
                        // Drain cycle after the last beat: the final write is
                        // on the i_mem port now, so the core may leave reset.
                        cur      <= ST_RUN;
                        core_rst <= 1'b0;
                    end else if (beat) begin
                        if (full) begin
                            cur               <= ST_ERR;
                            in_ready          <= 1'b0;
                            done              <= 1'b1;
                            err[BOOT_ERR_OVF] <= 1'b1;
                        end else begin
                            imem_we    <= 1'b1;
                            imem_addr  <= BASE_ADDR + (ADDR_W'(word_cnt) << 2);
                            imem_wdata <= in_data;
                            word_cnt   <= word_cnt + WC_W'(1);
                            if (in_last)
                                in_ready <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    // End of test takes priority over a same-cycle timeout.
                    if (eot_valid) begin
                        cur      <= ST_DONE;
                        core_rst <= 1'b1;
                        done     <= 1'b1;
                        pass     <= (eot_code == EOT_PASS_CODE);
                    end else if (wd_timeout) begin
                        cur               <= ST_ERR;
                        core_rst          <= 1'b1;
                        done              <= 1'b1;
                        err[BOOT_ERR_TMO] <= 1'b1;
                    end
                end
                default: begin
                    cur      <= ST_IDLE;
                    core_rst <= 1'b1;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
